// File: rtl/tlb_op_seq.sv
`default_nettype none
// ============================================================================
// Module   : tlb_op_seq
// Purpose  : Commit-time sequencer for the TLBP / TLBR / TLBWI / TLBWR
//            instructions. Latches operands from CP0, issues one request to
//            the TLB, returns TLBP/TLBR results as a one-cycle CP0 write-back,
//            requests a refetch flush after TLBR/TLBWI/TLBWR, and owns the
//            CP0 Random counter.
// Ports    : clk/reset              - clock, synchronous active-high reset
//            req_*, stall, abort    - pipeline commit interface
//            cp0_*                  - CP0 register operands
//            random                 - CP0 Random value
//            tlb_req_*/tlb_resp_*   - TLB request/response interface
//            cp0_wb_*               - CP0 write-back pulse (TLBP/TLBR)
//            flush_valid/flush_pc   - refetch request (pc of TLB op + 4)
// Revision : 1.0 - initial release
// ============================================================================
module tlb_op_seq #(
  parameter int TLB_ENTRIES = 16,
  parameter int IDX_W       = $clog2(TLB_ENTRIES)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  input  logic [1:0]       req_op,
  input  logic [31:0]      req_pc,
  output logic             req_ready,
  output logic             stall,
  input  logic             abort,
  input  logic [31:0]      cp0_index,
  input  logic [31:0]      cp0_wired,
  input  logic             cp0_wired_we,
  input  logic [31:0]      cp0_entry_hi,
  input  logic [31:0]      cp0_entry_lo0,
  input  logic [31:0]      cp0_entry_lo1,
  output logic [IDX_W-1:0] random,
  output logic             tlb_req_valid,
  input  logic             tlb_req_ready,
  output logic [1:0]       tlb_req_op,
  output logic [IDX_W-1:0] tlb_req_idx,
  output logic [31:0]      tlb_req_hi,
  output logic [31:0]      tlb_req_lo0,
  output logic [31:0]      tlb_req_lo1,
  input  logic             tlb_resp_valid,
  input  logic             tlb_resp_hit,
  input  logic [IDX_W-1:0] tlb_resp_idx,
  input  logic [31:0]      tlb_resp_hi,
  input  logic [31:0]      tlb_resp_lo0,
  input  logic [31:0]      tlb_resp_lo1,
  output logic             cp0_wb_valid,
  output logic [1:0]       cp0_wb_op,
  output logic [31:0]      cp0_wb_index,
  output logic [31:0]      cp0_wb_hi,
  output logic [31:0]      cp0_wb_lo0,
  output logic [31:0]      cp0_wb_lo1,
  output logic             flush_valid,
  output logic [31:0]      flush_pc
);

  localparam logic [1:0]       c_op_tlbp  = 2'd0;
  localparam logic [1:0]       c_op_tlbr  = 2'd1;
  localparam logic [1:0]       c_op_tlbwi = 2'd2;
  localparam logic [1:0]       c_op_tlbwr = 2'd3;
  localparam logic [IDX_W-1:0] c_rand_max = IDX_W'(TLB_ENTRIES - 1);
  localparam logic [31:0]      c_probe_miss = 32'h8000_0000;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo0_q, lo0_d;
  logic [31:0]      lo1_q, lo1_d;
  logic [31:0]      flush_pc_q, flush_pc_d;
  logic [31:0]      wb_index_q, wb_index_d;
  logic [31:0]      wb_hi_q, wb_hi_d;
  logic [31:0]      wb_lo0_q, wb_lo0_d;
  logic [31:0]      wb_lo1_q, wb_lo1_d;
  logic [IDX_W-1:0] random_q, random_d;

  logic w_accept;
  logic w_wired_big;
  logic w_unused_bits;

  // Only the low index bits of Index select an entry.
  assign w_unused_bits = ^cp0_index[31:IDX_W];

  // A Wired value at or beyond the TLB size leaves no random-replaceable
  // entries; Random then parks at the top entry.
  assign w_wired_big = |cp0_wired[31:IDX_W];

  // ---------------------------------------------------------------------
  // Random counter: counts down from the top entry and reloads after it
  // has presented the Wired boundary value, so it cycles over [wired, max].
  // ---------------------------------------------------------------------
  always_comb begin
    random_d = random_q - IDX_W'(1);
    if (cp0_wired_we || w_wired_big || (random_q <= cp0_wired[IDX_W-1:0])) begin
      random_d = c_rand_max;
    end
  end

  // ---------------------------------------------------------------------
  // Sequencer next-state and outputs
  // ---------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    idx_d      = idx_q;
    hi_d       = hi_q;
    lo0_d      = lo0_q;
    lo1_d      = lo1_q;
    flush_pc_d = flush_pc_q;
    wb_index_d = wb_index_q;
    wb_hi_d    = wb_hi_q;
    wb_lo0_d   = wb_lo0_q;
    wb_lo1_d   = wb_lo1_q;

    // abort beats a same-cycle request in IDLE
    w_accept = (state_q == S_IDLE) && req_valid && !abort;

    case (state_q)
      S_IDLE: begin
        if (w_accept) begin
          state_d = S_ISSUE;
          op_d    = req_op;
          hi_d    = cp0_entry_hi;
          lo0_d   = cp0_entry_lo0;
          lo1_d   = cp0_entry_lo1;
          // Only pc+4 is ever needed, so store the refetch address directly.
          flush_pc_d = req_pc + 32'd4;
          case (req_op)
            c_op_tlbr, c_op_tlbwi: idx_d = cp0_index[IDX_W-1:0];
            c_op_tlbwr:            idx_d = random_q;
            default:               idx_d = '0;
          endcase
        end
      end
      S_ISSUE: begin
        // Once the TLB has taken the request the op is committed, so a
        // same-cycle abort is ignored.
        if (tlb_req_ready) begin
          state_d = S_WAIT;
        end else if (abort) begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (tlb_resp_valid) begin
          state_d    = S_DONE;
          wb_index_d = tlb_resp_hit ? {{(32-IDX_W){1'b0}}, tlb_resp_idx} : c_probe_miss;
          wb_hi_d    = tlb_resp_hi;
          wb_lo0_d   = tlb_resp_lo0;
          wb_lo1_d   = tlb_resp_lo1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    req_ready     = (state_q == S_IDLE) && !reset;
    stall         = w_accept || (state_q == S_ISSUE) || (state_q == S_WAIT);
    tlb_req_valid = (state_q == S_ISSUE);
    cp0_wb_valid  = (state_q == S_DONE) && ((op_q == c_op_tlbp) || (op_q == c_op_tlbr));
    flush_valid   = (state_q == S_DONE) && (op_q != c_op_tlbp);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      op_q       <= '0;
      idx_q      <= '0;
      hi_q       <= '0;
      lo0_q      <= '0;
      lo1_q      <= '0;
      flush_pc_q <= '0;
      wb_index_q <= '0;
      wb_hi_q    <= '0;
      wb_lo0_q   <= '0;
      wb_lo1_q   <= '0;
      random_q   <= c_rand_max;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      idx_q      <= idx_d;
      hi_q       <= hi_d;
      lo0_q      <= lo0_d;
      lo1_q      <= lo1_d;
      flush_pc_q <= flush_pc_d;
      wb_index_q <= wb_index_d;
      wb_hi_q    <= wb_hi_d;
      wb_lo0_q   <= wb_lo0_d;
      wb_lo1_q   <= wb_lo1_d;
      random_q   <= random_d;
    end
  end

  assign random       = random_q;
  assign tlb_req_op   = op_q;
  assign tlb_req_idx  = idx_q;
  assign tlb_req_hi   = hi_q;
  assign tlb_req_lo0  = lo0_q;
  assign tlb_req_lo1  = lo1_q;
  assign cp0_wb_op    = op_q;
  assign cp0_wb_index = wb_index_q;
  assign cp0_wb_hi    = wb_hi_q;
  assign cp0_wb_lo0   = wb_lo0_q;
  assign cp0_wb_lo1   = wb_lo1_q;
  assign flush_pc     = flush_pc_q;

endmodule
`default_nettype wire

// File: tb/tb_tlb_op_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_tlb_op_seq
// Purpose  : Self-checking bench for tlb_op_seq. A driver issues TLB ops and
//            plays the TLB; expected TLB requests and CP0/flush outcomes are
//            queued and consumed by an independent monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tlb_op_seq;

  localparam int N  = 16;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic [1:0]    req_op = '0;
  logic [31:0]   req_pc = '0;
  logic          req_ready;
  logic          stall;
  logic          abort = 1'b0;
  logic [31:0]   cp0_index = '0;
  logic [31:0]   cp0_wired = 32'd4;
  logic          cp0_wired_we = 1'b0;
  logic [31:0]   cp0_entry_hi = '0;
  logic [31:0]   cp0_entry_lo0 = '0;
  logic [31:0]   cp0_entry_lo1 = '0;
  logic [IW-1:0] random;
  logic          tlb_req_valid;
  logic          tlb_req_ready = 1'b0;
  logic [1:0]    tlb_req_op;
  logic [IW-1:0] tlb_req_idx;
  logic [31:0]   tlb_req_hi, tlb_req_lo0, tlb_req_lo1;
  logic          tlb_resp_valid = 1'b0;
  logic          tlb_resp_hit = 1'b0;
  logic [IW-1:0] tlb_resp_idx = '0;
  logic [31:0]   tlb_resp_hi = '0, tlb_resp_lo0 = '0, tlb_resp_lo1 = '0;
  logic          cp0_wb_valid;
  logic [1:0]    cp0_wb_op;
  logic [31:0]   cp0_wb_index, cp0_wb_hi, cp0_wb_lo0, cp0_wb_lo1;
  logic          flush_valid;
  logic [31:0]   flush_pc;

  always #5 clk = ~clk;

  tlb_op_seq #(.TLB_ENTRIES(N)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_op(req_op), .req_pc(req_pc),
    .req_ready(req_ready), .stall(stall), .abort(abort),
    .cp0_index(cp0_index), .cp0_wired(cp0_wired), .cp0_wired_we(cp0_wired_we),
    .cp0_entry_hi(cp0_entry_hi), .cp0_entry_lo0(cp0_entry_lo0), .cp0_entry_lo1(cp0_entry_lo1),
    .random(random),
    .tlb_req_valid(tlb_req_valid), .tlb_req_ready(tlb_req_ready), .tlb_req_op(tlb_req_op),
    .tlb_req_idx(tlb_req_idx), .tlb_req_hi(tlb_req_hi), .tlb_req_lo0(tlb_req_lo0),
    .tlb_req_lo1(tlb_req_lo1),
    .tlb_resp_valid(tlb_resp_valid), .tlb_resp_hit(tlb_resp_hit), .tlb_resp_idx(tlb_resp_idx),
    .tlb_resp_hi(tlb_resp_hi), .tlb_resp_lo0(tlb_resp_lo0), .tlb_resp_lo1(tlb_resp_lo1),
    .cp0_wb_valid(cp0_wb_valid), .cp0_wb_op(cp0_wb_op), .cp0_wb_index(cp0_wb_index),
    .cp0_wb_hi(cp0_wb_hi), .cp0_wb_lo0(cp0_wb_lo0), .cp0_wb_lo1(cp0_wb_lo1),
    .flush_valid(flush_valid), .flush_pc(flush_pc)
  );

  typedef struct {
    logic [1:0]    op;
    logic [IW-1:0] idx;
    logic [31:0]   hi, lo0, lo1;
  } req_t;

  typedef struct {
    logic          wb;
    logic          fl;
    logic [1:0]    op;
    logic [31:0]   index, hi, lo0, lo1, fpc;
  } out_t;

  req_t req_q[$];
  out_t out_q[$];
  int   total = 0;
  int   bad   = 0;
  bit   mon_en = 1'b0;
  bit   bg_en  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Random reference: cycles since the last reload (reset or Wired write);
  // the counter walks max, max-1, ... down to Wired, then starts again.
  int          rk = 0;
  logic [31:0] wired_m = 32'd4;
  always @(posedge clk) begin
    if (reset || cp0_wired_we) begin
      rk      <= 0;
      wired_m <= cp0_wired;
    end else begin
      rk <= rk + 1;
    end
  end

  function automatic logic [IW-1:0] model_random();
    int span;
    if (wired_m >= N) return IW'(N - 1);
    span = N - int'(wired_m);
    return IW'(N - 1 - (rk % span));
  endfunction

  // ---------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------
  always @(negedge clk) begin
    if (mon_en && !reset) begin
      check("random", 32'(random), 32'(model_random()));
      if (tlb_req_valid) begin
        if (req_q.size() == 0) begin
          total++; bad++;
          $display("FAIL tlb_req_unexpected: got op=%0d idx=%0d expected no request", tlb_req_op, tlb_req_idx);
        end else begin
          check("tlb_req_op",  32'(tlb_req_op),  32'(req_q[0].op));
          check("tlb_req_idx", 32'(tlb_req_idx), 32'(req_q[0].idx));
          check("tlb_req_hi",  tlb_req_hi,  req_q[0].hi);
          check("tlb_req_lo0", tlb_req_lo0, req_q[0].lo0);
          check("tlb_req_lo1", tlb_req_lo1, req_q[0].lo1);
          if (tlb_req_ready) void'(req_q.pop_front());
        end
      end
      if (cp0_wb_valid || flush_valid) begin
        if (out_q.size() == 0) begin
          total++; bad++;
          $display("FAIL outcome_unexpected: got wb=%0b flush=%0b expected none", cp0_wb_valid, flush_valid);
        end else begin
          out_t o;
          o = out_q.pop_front();
          check("wb_valid",    32'(cp0_wb_valid), 32'(o.wb));
          check("flush_valid", 32'(flush_valid),  32'(o.fl));
          check("stall_done",  32'(stall), 32'd0);
          check("ready_done",  32'(req_ready), 32'd0);
          if (o.wb) check("wb_op", 32'(cp0_wb_op), 32'(o.op));
          if (o.op == 2'd0) check("wb_index", cp0_wb_index, o.index);
          if (o.op == 2'd1) begin
            check("wb_hi",  cp0_wb_hi,  o.hi);
            check("wb_lo0", cp0_wb_lo0, o.lo0);
            check("wb_lo1", cp0_wb_lo1, o.lo1);
          end
          if (o.fl) check("flush_pc", flush_pc, o.fpc);
        end
      end
    end
  end

  // Occasional Wired writes, including out-of-range values.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (bg_en && $urandom_range(39) == 0) begin
        cp0_wired_we = 1'b1;
        cp0_wired    = ($urandom_range(4) == 0) ? 32'h0001_0003 : 32'($urandom_range(17));
      end else begin
        cp0_wired_we = 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Driver + TLB responder
  // mode 0: normal, 1: abort while the TLB back-pressures, 2: reset in WAIT
  // ---------------------------------------------------------------------
  task automatic run_op(input logic [1:0] op, input bit pre_abort, input int bp,
                        input int lat, input int mode);
    int   n;
    req_t r;
    out_t o;
    n = 0;
    while (!req_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!req_ready) begin
      total++; bad++;
      $display("FAIL ready_timeout: got req_ready=0 expected 1 within 50 cycles");
      return;
    end
    req_op        = op;
    req_pc        = $urandom & 32'hFFFF_FFFC;
    cp0_index     = $urandom;
    cp0_entry_hi  = $urandom;
    cp0_entry_lo0 = $urandom;
    cp0_entry_lo1 = $urandom;
    if (pre_abort) begin
      req_valid = 1'b1;
      abort     = 1'b1;
      #1 check("stall_pre_abort", 32'(stall), 32'd0);
      @(posedge clk); #1;
      abort = 1'b0;
      check("ready_pre_abort", 32'(req_ready), 32'd1);
    end
    req_valid = 1'b1;
    r.op  = op;
    r.idx = (op == 2'd0) ? IW'(0) : (op == 2'd3) ? model_random() : cp0_index[IW-1:0];
    r.hi  = cp0_entry_hi;
    r.lo0 = cp0_entry_lo0;
    r.lo1 = cp0_entry_lo1;
    req_q.push_back(r);
    #1 check("stall_accept", 32'(stall), 32'd1);
    @(posedge clk); #1;
    // Requests outside IDLE must be ignored.
    req_valid = 1'($urandom_range(1));
    req_op    = 2'($urandom_range(3));
    for (int i = 0; i < bp; i++) begin
      tlb_req_ready  = 1'b0;
      tlb_resp_valid = 1'($urandom_range(1));
      abort          = (mode == 1 && i == bp - 1);
      #1 check("stall_issue", 32'(stall), 32'd1);
      @(posedge clk); #1;
      abort = 1'b0;
      tlb_resp_valid = 1'b0;
    end
    if (mode == 1) begin
      req_valid = 1'b0;
      void'(req_q.pop_back());
      check("ready_after_abort", 32'(req_ready), 32'd1);
      check("no_req_after_abort", 32'(tlb_req_valid), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      return;
    end
    tlb_req_ready = 1'b1;
    abort         = 1'($urandom_range(1));
    @(posedge clk); #1;
    tlb_req_ready = 1'b0;
    abort         = 1'b0;
    for (int i = 0; i < lat; i++) begin
      abort = 1'($urandom_range(1));
      #1 check("stall_wait", 32'(stall), 32'd1);
      @(posedge clk); #1;
      abort = 1'b0;
    end
    tlb_resp_hit = 1'($urandom_range(1));
    tlb_resp_idx = IW'($urandom_range(N - 1));
    tlb_resp_hi  = $urandom;
    tlb_resp_lo0 = $urandom;
    tlb_resp_lo1 = $urandom;
    if (mode == 2) begin
      reset = 1'b1;
      @(posedge clk); #1;
      reset     = 1'b0;
      req_valid = 1'b0;
      #1;
      check("rst_ready",     32'(req_ready), 32'd1);
      check("rst_random",    32'(random), 32'd15);
      check("rst_tlb_valid", 32'(tlb_req_valid), 32'd0);
      check("rst_wb",        32'(cp0_wb_valid), 32'd0);
      check("rst_flush",     32'(flush_valid), 32'd0);
      tlb_resp_valid = 1'b1;
      @(posedge clk); #1;
      tlb_resp_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      return;
    end
    tlb_resp_valid = 1'b1;
    o.wb    = (op == 2'd0) || (op == 2'd1);
    o.fl    = (op != 2'd0);
    o.op    = op;
    o.index = tlb_resp_hit ? 32'(tlb_resp_idx) : 32'h8000_0000;
    o.hi    = tlb_resp_hi;
    o.lo0   = tlb_resp_lo0;
    o.lo1   = tlb_resp_lo1;
    o.fpc   = req_pc + 32'd4;
    out_q.push_back(o);
    @(posedge clk); #1;
    tlb_resp_valid = 1'b0;
    req_valid      = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset_ready_low", 32'(req_ready), 32'd0);
    reset = 1'b0;
    #1;
    check("reset_ready",    32'(req_ready), 32'd1);
    check("reset_random",   32'(random), 32'd15);
    check("reset_stall",    32'(stall), 32'd0);
    check("reset_tlb_req",  32'(tlb_req_valid), 32'd0);
    check("reset_wb_index", cp0_wb_index, 32'd0);
    check("reset_flush_pc", flush_pc, 32'd0);
    mon_en = 1'b1;

    run_op(2'd0, 1'b0, 0, 0, 0);   // TLBP, minimum latency
    run_op(2'd0, 1'b0, 0, 1, 0);   // TLBP again
    // TLBWR at Random == 7 with Wired = 4
    cp0_wired = 32'd4; cp0_wired_we = 1'b1;
    @(posedge clk); #1;
    cp0_wired_we = 1'b0;
    for (int i = 0; i < 40 && model_random() != IW'(7); i++) begin
      @(posedge clk); #1;
    end
    check("random_reaches_7", 32'(random), 32'd7);
    run_op(2'd3, 1'b0, 0, 0, 0);
    run_op(2'd2, 1'b0, 3, 0, 1);   // TLBWI back-pressure + abort
    run_op(2'd1, 1'b0, 0, 4, 0);   // TLBR, 5-cycle TLB latency
    run_op(2'd1, 1'b0, 1, 2, 2);   // reset while waiting for the TLB
    run_op(2'd2, 1'b1, 2, 1, 0);   // abort beats a request in IDLE

    bg_en = 1'b1;
    for (int k = 0; k < 150; k++) begin
      int m;
      m = ($urandom_range(9) == 0) ? 1 : (($urandom_range(24) == 0) ? 2 : 0);
      run_op(2'($urandom_range(3)), 1'($urandom_range(4) == 0),
             (m == 1) ? int'($urandom_range(4, 1)) : int'($urandom_range(3)),
             int'($urandom_range(5)), m);
      if ($urandom_range(2) == 0) begin
        repeat ($urandom_range(4)) @(posedge clk);
        #1;
      end
    end
    bg_en = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("req_queue_drained", 32'(req_q.size()), 32'd0);
    check("out_queue_drained", 32'(out_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    total++; bad++;
    $display("FAIL watchdog: got no completion expected finish before 1ms");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
